// File: rtl/cv32e40x_alu_share_arb_if.sv
// Request/grant bundle between the shifter/CLZ arbiter and its two requesters.
// The master side is the requesters; the slave side is the arbiter.
interface cv32e40x_alu_share_arb_if;
    logic alu_req_i;
    logic alu_gnt_o;
    logic div_req_i;
    logic div_last_i;
    logic div_gnt_o;
    logic div_en_o;

    modport master (
        output alu_req_i, div_req_i, div_last_i,
        input  alu_gnt_o, div_gnt_o, div_en_o
    );

    modport slave (
        input  alu_req_i, div_req_i, div_last_i,
        output alu_gnt_o, div_gnt_o, div_en_o
    );
endinterface

// File: rtl/cv32e40x_alu_share_arb.sv
// Per-cycle arbiter for the ALU shifter/CLZ datapath shared between the EX ALU path and the divider.
// Optional macro CV32E40X_ALU_ARB_STATS_EN adds a saturating ALU-conflict counter output.
module cv32e40x_alu_share_arb #(
    parameter int unsigned MAX_DIV_BURST = 8,
    parameter int unsigned MAX_DIV_WAIT  = 4,
    parameter int unsigned CNT_W         = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       kill_i,
    cv32e40x_alu_share_arb_if.slave    arb_if,
    output logic [1:0]                 state_o,
    output logic [CNT_W-1:0]           burst_cnt_o
`ifdef CV32E40X_ALU_ARB_STATS_EN
    ,
    output logic [15:0]                conflict_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_DIV   = 2'b01,
        S_YIELD = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] LP_BURST_MAX = CNT_W'(MAX_DIV_BURST);
    localparam logic [CNT_W-1:0] LP_WAIT_MAX  = CNT_W'(MAX_DIV_WAIT);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [CNT_W-1:0] w_burst_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_nxt;
    logic             w_alu_gnt;
    logic             w_div_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_burst_cnt <= '0;
            r_wait_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_wait_cnt  <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst_cnt;
        w_wait_nxt  = r_wait_cnt;
        w_alu_gnt   = 1'b0;
        w_div_gnt   = 1'b0;
        if (kill_i) begin
            w_state_nxt = S_IDLE;
            w_burst_nxt = '0;
            w_wait_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arb_if.alu_req_i && arb_if.div_req_i) begin
                        if (r_wait_cnt < LP_WAIT_MAX) begin
                            w_alu_gnt  = 1'b1;
                            w_wait_nxt = r_wait_cnt + 1'b1;
                        end else begin
                            w_div_gnt  = 1'b1;
                        end
                    end else begin
                        w_alu_gnt = arb_if.alu_req_i;
                        w_div_gnt = arb_if.div_req_i;
                    end
                    if (w_div_gnt) begin
                        w_wait_nxt = '0;
                        if (!arb_if.div_last_i) begin
                            w_state_nxt = S_DIV;
                            w_burst_nxt = CNT_W'(1);
                        end
                    end
                end
                S_DIV: begin
                    // A stalled divider lends the datapath to the ALU without ending its burst.
                    if (!arb_if.div_req_i) begin
                        w_alu_gnt = arb_if.alu_req_i;
                    end else if ((r_burst_cnt == LP_BURST_MAX) && arb_if.alu_req_i && !arb_if.div_last_i) begin
                        w_alu_gnt   = 1'b1;
                        w_state_nxt = S_YIELD;
                    end else begin
                        w_div_gnt = 1'b1;
                        if (arb_if.div_last_i) begin
                            w_state_nxt = S_IDLE;
                            w_burst_nxt = '0;
                        end else if (r_burst_cnt != LP_BURST_MAX) begin
                            w_burst_nxt = r_burst_cnt + 1'b1;
                        end
                    end
                end
                S_YIELD: begin
                    w_state_nxt = S_DIV;
                    w_burst_nxt = '0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_burst_nxt = '0;
                    w_wait_nxt  = '0;
                end
            endcase
        end
    end

    // Grants are forced low while reset is held so nothing leaks out before the first edge.
    assign arb_if.alu_gnt_o = w_alu_gnt & ~rst;
    assign arb_if.div_gnt_o = w_div_gnt & ~rst;
    assign arb_if.div_en_o  = w_div_gnt & ~rst;
    assign state_o          = r_state;
    assign burst_cnt_o      = r_burst_cnt;

`ifdef CV32E40X_ALU_ARB_STATS_EN
    logic [15:0] r_conflict_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict_cnt <= '0;
        end else if (arb_if.alu_req_i && !w_alu_gnt && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt_o = r_conflict_cnt;
`endif

endmodule
